// File: rtl/aes_block_gather.sv
// Purpose: packs WORD_W-bit words into BLK_W-bit blocks for the aes128 core, zero-padding and flagging short blocks.
// Latency: 1 cycle from the completing word's accept to blk_valid; blocks stream back-to-back with no bubble.
// Backpressure: double buffered; a completed block parks in the assembly register and in_ready drops until the core takes the output.
module aes_block_gather #(
  parameter int WORD_W    = 32,
  parameter int BLK_W     = 128,
  parameter int MSW_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [BLK_W-1:0]  blk_data,
  output logic              blk_short,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam int WORDS = BLK_W / WORD_W;
  localparam int WC_W  = $clog2(WORDS);
  localparam logic [WC_W-1:0] LAST_SLOT = WC_W'(WORDS - 1);

  // A block travels with its short flag so both registers move it as one unit.
  typedef struct packed {
    logic             is_short;
    logic [BLK_W-1:0] data;
  } blk_t;

  // Encoding is {asm_full, blk_valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WC_W-1:0] wcnt_q;
  logic [WC_W-1:0] slot_idx;
  blk_t            asm_q;
  blk_t            out_q;
  blk_t            asm_merged;
  logic [CNT_W-1:0] cnt_q;
  logic            asm_full;
  logic            accept;
  logic            complete;
  logic            out_free;
  logic            handshake;

  assign accept    = in_valid & in_ready;
  assign complete  = accept & (in_last | (wcnt_q == LAST_SLOT));
  assign out_free  = !blk_valid | blk_ready;
  assign handshake = blk_valid & blk_ready;

  // Word slot in the block: first word at the top when MSW_FIRST, else at the bottom.
  assign slot_idx = (MSW_FIRST != 0) ? (LAST_SLOT - wcnt_q) : wcnt_q;

  // State register: tracks whether the output and assembly registers hold blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state from completions and core handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (complete) state_d = ONE;
      ONE: begin
        if (complete && !blk_ready)      state_d = FULL;
        else if (!complete && blk_ready) state_d = EMPTY;
      end
      FULL:    if (blk_ready) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs decoded from state only, so nothing on the input side reaches blk_*.
  always_comb begin
    in_ready  = 1'b0;
    blk_valid = 1'b0;
    asm_full  = 1'b0;
    case (state_q)
      EMPTY: in_ready = !rst;
      ONE: begin
        in_ready  = !rst;
        blk_valid = 1'b1;
      end
      FULL: begin
        blk_valid = 1'b1;
        asm_full  = 1'b1;
      end
      default: ;
    endcase
  end

  // Assembly register with the incoming word merged into its slot; unfilled slots stay zero.
  always_comb begin
    asm_merged          = asm_q;
    asm_merged.is_short = in_last & (wcnt_q != LAST_SLOT);
    for (int i = 0; i < WORDS; i++) begin
      if (WC_W'(i) == slot_idx) asm_merged.data[i*WORD_W +: WORD_W] = in_data;
    end
  end

  // Datapath: fill asm_q, bypass a completed block straight to the output when it is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
      asm_q  <= '0;
      out_q  <= '0;
    end else begin
      if (accept) wcnt_q <= complete ? '0 : wcnt_q + WC_W'(1);
      if (asm_full) begin
        if (blk_ready) begin
          out_q <= asm_q;
          asm_q <= '0;
        end
      end else if (accept) begin
        if (complete && out_free) begin
          out_q <= asm_merged;
          asm_q <= '0;
        end else begin
          asm_q <= asm_merged;
        end
      end
    end
  end

  // Delivered-block counter, wrapping naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt_q <= '0;
    else if (handshake) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign blk_data  = out_q.data;
  assign blk_short = out_q.is_short;
  assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_aes_block_gather.sv
// Purpose: directed scoreboard bench for aes_block_gather (4 x 32-bit words per block, MSW first, 4-bit counter).
// Latency: expected blocks are queued at issue; a negedge monitor pops one per output handshake.
// Backpressure: blk_ready is driven per test; the monitor also checks that a held block does not change.
module tb_aes_block_gather;

  localparam int WORD_W = 32;
  localparam int BLK_W  = 128;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [BLK_W-1:0]  blk_data;
  logic              blk_short;
  logic              blk_valid;
  logic              blk_ready = 1'b0;
  logic [CNT_W-1:0]  blk_cnt;

  always #5 clk = ~clk;

  aes_block_gather #(
    .WORD_W(WORD_W), .BLK_W(BLK_W), .MSW_FIRST(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .blk_data(blk_data), .blk_short(blk_short), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_cnt(blk_cnt)
  );

  typedef struct packed {
    logic             s;
    logic [BLK_W-1:0] d;
  } exp_t;

  exp_t             q[$];
  exp_t             mon_e;
  int               nvec = 0;
  int               nerr = 0;
  int               stalls = 0;
  logic [CNT_W-1:0] cnt_model = '0;
  logic             hold_prev = 1'b0;
  logic [BLK_W-1:0] prev_d = '0;
  logic             prev_s = 1'b0;

  task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one word and hold it until accepted (bounded); returns #1 after the accepting edge.
  task automatic send_word(input logic [WORD_W-1:0] d, input logic last);
    int waited = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      stalls++;
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      nvec++;
      nerr++;
      $display("FAIL send_word_timeout: in_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Queue a full 4-word block as expected, then send its words first-word-first.
  task automatic send_blk(input logic [BLK_W-1:0] blk, input logic last4);
    q.push_back({1'b0, blk});
    for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], last4 && (i == 3));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout: %0d blocks outstanding, expected 0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    chk("rst_blk_data", blk_data, 0);
    chk("rst_blk_short", blk_short, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  // Monitor: counter tracking, hold stability and in-order block comparison on every handshake.
  always @(negedge clk) begin
    if (rst) begin
      cnt_model = '0;
      hold_prev = 1'b0;
    end else begin
      chk("mon_blk_cnt", blk_cnt, cnt_model);
      if (hold_prev && blk_valid) begin
        chk("hold_data", blk_data, prev_d);
        chk("hold_short", blk_short, prev_s);
      end
      if (blk_valid && blk_ready) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_block: got %0h, expected no block", blk_data);
        end else begin
          mon_e = q.pop_front();
          chk("blk_data", blk_data, mon_e.d);
          chk("blk_short", blk_short, mon_e.s);
        end
        cnt_model = cnt_model + 1'b1;
      end
      hold_prev = blk_valid && !blk_ready;
      prev_d    = blk_data;
      prev_s    = blk_short;
    end
  end

  initial begin
    logic [BLK_W-1:0] blk;

    // T1: reset mid-block discards the partial words
    do_reset();
    blk_ready = 1'b1;
    send_word(32'hAAAAAAAA, 1'b0);
    send_word(32'hBBBBBBBB, 1'b0);
    do_reset();
    send_blk(128'h11111111_22222222_33333333_44444444, 1'b0);
    wait_drain();
    chk("t1_cnt", blk_cnt, 1);

    // T2: ordering and one-cycle latency
    do_reset();
    blk_ready = 1'b1;
    send_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
    chk("t2_valid", blk_valid, 1);
    chk("t2_data", blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("t2_short", blk_short, 0);
    wait_drain();
    chk("t2_cnt", blk_cnt, 1);

    // T3: short block is zero padded and flagged
    q.push_back({1'b1, 128'hDEADBEEF_01234567_00000000_00000000});
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'h01234567, 1'b1);
    chk("t3_valid", blk_valid, 1);
    chk("t3_data", blk_data, 128'hDEADBEEF_01234567_00000000_00000000);
    chk("t3_short", blk_short, 1);
    wait_drain();
    chk("t3_cnt", blk_cnt, 2);

    // T4: backpressure parks block B in the assembly register
    do_reset();
    blk_ready = 1'b0;
    send_blk(128'h40000000_40000001_40000002_40000003, 1'b0);
    send_blk(128'h40000004_40000005_40000006_40000007, 1'b0);
    chk("t4_full_in_ready", in_ready, 0);
    chk("t4_a_valid", blk_valid, 1);
    chk("t4_a_data", blk_data, 128'h40000000_40000001_40000002_40000003);
    in_data  = 32'h40000008;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t4_ignored_in_ready", in_ready, 0);
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    chk("t4_b_valid", blk_valid, 1);
    chk("t4_b_data", blk_data, 128'h40000004_40000005_40000006_40000007);
    chk("t4_b_in_ready", in_ready, 1);
    chk("t4_b_cnt", blk_cnt, 1);
    send_blk(128'h40000008_40000009_4000000A_4000000B, 1'b0);
    chk("t4_c_in_ready", in_ready, 0);
    blk_ready = 1'b1;
    wait_drain();
    chk("t4_cnt", blk_cnt, 3);

    // T5: 40 back-to-back words, no stalls
    do_reset();
    blk_ready = 1'b1;
    stalls = 0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) blk[127-32*k -: 32] = 32'h50000000 + 32'(4*b + k);
      send_blk(blk, 1'b0);
    end
    wait_drain();
    chk("t5_stalls", stalls, 0);
    chk("t5_cnt", blk_cnt, 10);

    // T6: 17 blocks wrap the 4-bit counter; in_last on word 4 is not short
    do_reset();
    blk_ready = 1'b1;
    for (int b = 0; b < 17; b++) begin
      for (int k = 0; k < 4; k++) blk[127-32*k -: 32] = 32'h60000000 + 32'(16*b + k);
      send_blk(blk, 1'b1);
    end
    wait_drain();
    chk("t6_cnt", blk_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
